// File: rtl/jtshouse_pkg.sv
// Shared constants and types for the jtshouse colour mixer.
// Palette bank selects, object pen codes and the RGB bundle.
package jtshouse_pkg;

  localparam logic [3:0]  OBJ_TRANSP = 4'hF;
  localparam logic [10:0] SHADOW_PEN = 11'h7FE;
  localparam logic [1:0]  PAL_OBJ    = 2'b00;
  localparam logic [1:0]  PAL_SCR    = 2'b01;
  localparam int          BLANK_DLY  = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Halving each channel darkens without any risk of underflow.
  function automatic rgb_t shade(input rgb_t c);
    rgb_t s;
    s.r = c.r >> 1;
    s.g = c.g >> 1;
    s.b = c.b >> 1;
    return s;
  endfunction

endpackage

// File: rtl/jtshouse_colmix_dly.sv
// N-deep shift register advancing on the pixel clock enable.
// Used to align the blanking signals with the colour pipeline.
module jtshouse_colmix_dly #(
  parameter int N = 3
) (
  input  logic rst,
  input  logic clk,
  input  logic cen,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else if (cen) begin
      r_sh <= (r_sh << 1) | N'(d);
    end
  end

  assign q = r_sh[N-1];

endmodule

// File: rtl/jtshouse_colmix.sv
// Final video mixer: tilemap/object merge, shadow pens,
// palette lookup and blank-aligned RGB output.
import jtshouse_pkg::*;

module jtshouse_colmix (
  input  logic        rst,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [10:0] scr_pxl,
  input  logic [2:0]  scr_prio,
  input  logic [10:0] obj_pxl,
  input  logic [2:0]  obj_prio,
  output logic [12:0] pal_addr,
  input  logic [23:0] pal_data,
  input  logic [3:0]  gfx_en,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);

  logic [10:0] r_scr_pxl0;
  logic [2:0]  r_scr_prio0;
  logic [10:0] r_obj_pxl0;
  logic [2:0]  r_obj_prio0;
  logic        r_obj_en0;
  logic        r_lhbl0;
  logic        r_lvbl0;

  logic [12:0] r_pal_addr;
  logic        r_shd1;
  rgb_t        r_col2;
  logic        r_shd2;
  rgb_t        r_col3;

  logic        w_obj_shd;
  logic        w_obj_opq;
  logic        w_obj_win;
  logic        w_blank_n;
  logic        w_unused;

  assign w_unused = ^gfx_en[2:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scr_pxl0  <= '0;
      r_scr_prio0 <= '0;
      r_obj_pxl0  <= '0;
      r_obj_prio0 <= '0;
      r_obj_en0   <= 1'b0;
      r_lhbl0     <= 1'b0;
      r_lvbl0     <= 1'b0;
    end else if (pxl_cen) begin
      r_scr_pxl0  <= gfx_en[0] ? scr_pxl : 11'd0;
      r_scr_prio0 <= scr_prio;
      r_obj_pxl0  <= obj_pxl;
      r_obj_prio0 <= obj_prio;
      r_obj_en0   <= gfx_en[3];
      r_lhbl0     <= LHBL;
      r_lvbl0     <= LVBL;
    end
  end

  // Shadow pen never draws itself; ties in priority go to objects.
  assign w_obj_shd = r_obj_pxl0 == SHADOW_PEN;
  assign w_obj_opq = r_obj_en0 && !w_obj_shd &&
                     (r_obj_pxl0[3:0] != OBJ_TRANSP);
  assign w_obj_win = r_obj_prio0 >= r_scr_prio0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pal_addr <= '0;
      r_shd1     <= 1'b0;
    end else if (pxl_cen) begin
      r_pal_addr <= (w_obj_opq && w_obj_win) ?
                    {PAL_OBJ, r_obj_pxl0} :
                    {PAL_SCR, r_scr_pxl0};
      r_shd1     <= w_obj_shd && w_obj_win && r_obj_en0;
    end
  end

  assign pal_addr = r_pal_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col2 <= '0;
      r_shd2 <= 1'b0;
      r_col3 <= '0;
    end else if (pxl_cen) begin
      r_col2 <= rgb_t'(pal_data);
      r_shd2 <= r_shd1;
      r_col3 <= r_shd2 ? shade(r_col2) : r_col2;
    end
  end

  jtshouse_colmix_dly #(.N(BLANK_DLY)) u_hb (
    .rst (rst),
    .clk (clk),
    .cen (pxl_cen),
    .d   (r_lhbl0),
    .q   (LHBL_dly)
  );

  jtshouse_colmix_dly #(.N(BLANK_DLY)) u_vb (
    .rst (rst),
    .clk (clk),
    .cen (pxl_cen),
    .d   (r_lvbl0),
    .q   (LVBL_dly)
  );

  // Both the colour and the blanks are registered, so the mask is glitch-free.
  assign w_blank_n = LHBL_dly & LVBL_dly;
  assign {red, green, blue} = w_blank_n ? r_col3 : 24'd0;

  a_cen_spacing: assert property (
    @(posedge clk) disable iff (rst) pxl_cen |=> !pxl_cen
  );

endmodule

// File: doc/jtshouse_colmix.md
Name: jtshouse_colmix

Overview:
- Final video stage after the C123 tilemap renderer and the object renderer.
- Merges the resolved tilemap pixel (11-bit index, 3-bit priority) with the object pixel and handles object shadow pens.
- Looks the winning index up in the palette BRAM and emits registered RGB with blanking delayed to match.
- All stages advance on pxl_cen, giving a fixed pixel latency.

Parameters:
- OBJ_TRANSP, 4'hF: object pen (pixel bits [3:0]) treated as transparent.
- SHADOW_PEN, 11'h7FE: full object index that darkens the underlying tilemap colour instead of drawing.
- BLANK_DLY, 3: pixel-clock delay of LHBL/LVBL; equals the colour pipeline depth.

Ports:
- rst  in  1  asynchronous, active-high reset
- clk  in  1  system clock
- pxl_cen  in  1  pixel clock enable; all pipeline stages advance only when high
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- scr_pxl  in  11  tilemap pixel index {palette,pen}
- scr_prio  in  3  tilemap winning-layer priority
- obj_pxl  in  11  object pixel index
- obj_prio  in  3  object priority
- pal_addr  out  13  palette BRAM address
- pal_data  in  24  palette BRAM data {R,G,B}; one-clk read latency
- gfx_en  in  4  debug enables: bit0 tilemap, bit3 objects
- red  out  8  red output
- green  out  8  green output
- blue  out  8  blue output
- LHBL_dly  out  1  LHBL delayed by BLANK_DLY pixels
- LVBL_dly  out  1  LVBL delayed by BLANK_DLY pixels

Behaviour:
- Reset: red, green and blue are 0; LHBL_dly and LVBL_dly are 0; pal_addr is 0; all pipeline registers and shadow flags are cleared.
- Stage S0 (pxl_cen): register the inputs.
  - gfx_en[0]=0 forces the tilemap index to 0.
  - gfx_en[3]=0 marks the object as transparent.
- Stage S1 (pxl_cen): select the winner.
  - obj_opaque = obj_pxl[3:0]!=OBJ_TRANSP and obj_pxl!=SHADOW_PEN.
  - If obj_opaque and obj_prio>=scr_prio: pal_addr <= {2'b00,obj_pxl}.
  - Otherwise: pal_addr <= {2'b01,scr_pxl}.
  - shadow <= (obj_pxl==SHADOW_PEN) and obj_prio>=scr_prio and gfx_en[3].
  - Ties in priority go to objects.
- Stage S2 (pxl_cen): capture pal_data.
  - pxl_cen must be spaced at least 2 clk apart so the BRAM has returned data. Back-to-back pxl_cen is out of spec and is flagged by a simulation assertion.
  - Carry shadow forward.
- Stage S3 (pxl_cen): output.
  - Shadow: each component is shifted right by 1, i.e. R>>1, G>>1, B>>1 with truncation, never underflow.
  - Not shadow: pass the colour through.
  - Outputs are forced to 0 when LHBL_dly or LVBL_dly is low, using the delayed blanks aligned to the same pixel.
- Latency:
  - Pixel at S0 on pxl_cen edge n appears on RGB after edge n+3.
  - LHBL_dly/LVBL_dly come from a BLANK_DLY-deep shift register clocked by pxl_cen, so they align exactly with the RGB.
- Hold: with pxl_cen low, every register holds and pal_addr is stable.
- Reset mid-frame: outputs go to 0 immediately (asynchronous). After release the first 3 pixels output black because the blank pipe is zero.
- No CPU port: palette writes are owned by the palette RAM module, and a write collision only corrupts the colour of one pixel.

Decomposition:
- jtshouse_pkg holds the shared constants: OBJ_TRANSP, SHADOW_PEN, palette bank selects PAL_OBJ=2'b00 and PAL_SCR=2'b01, and the 24-bit RGB typedef.
- One natural sub-module: jtshouse_colmix_dly, a generic N-deep pxl_cen-gated shift register used for the blanking signals. The rest is flat.

Test Plan:
- Priority win:
  - Stimulus: scr_pxl=11'h123 prio 2, obj_pxl=11'h045 prio 3, pal[0x0045]=24'hFF8040.
  - Required: pal_addr=13'h0045; RGB=FF/80/40 three pxl_cen later.
- Tie and loss:
  - obj prio 2 = scr prio 2: object wins.
  - obj prio 1: pal_addr=13'h0923 ({2'b01,11'h123}) and RGB from that entry.
- Transparency and debug:
  - obj_pxl=11'h04F: scroll shown.
  - gfx_en[3]=0 with opaque obj: scroll shown.
  - gfx_en[0]=0: pal_addr=13'h0800 when no object covers the pixel.
- Shadow:
  - obj_pxl=11'h7FE prio 7 over scroll entry 24'hFF7F01 -> RGB=7F/3F/00.
  - The same shadow pen with prio 0 under scr prio 4 -> unshaded FF/7F/01.
- Blanking alignment:
  - Toggle LHBL low for 10 pixels.
  - Required: LHBL_dly low exactly 3 pxl_cen later for 10 pixels, with RGB=0 throughout.
  - pxl_cen held low for 20 clk -> outputs frozen.
- Async reset: assert rst mid-line with RGB non-zero -> RGB=0 and LHBL_dly=0 on the same clock. After release, black for 3 pixels, then valid data.
